// File: rtl/jk_counter_bank_pkg.sv
// Shared definitions for the JK counter bank: mode encodings applied on the
// two-bit mode input.
package jk_counter_bank_pkg;

  localparam logic [1:0] MODE_JK   = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/jk_counter_bank_cell.sv
// Single JK flip-flop cell with synchronous active-high reset to zero.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qbar
);

  logic state_q;
  logic state_d;

  always_comb begin
    state_d = state_q;
    case ({j, k})
      2'b00:   state_d = state_q;
      2'b01:   state_d = 1'b0;
      2'b10:   state_d = 1'b1;
      default: state_d = ~state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= 1'b0;
    end else begin
      state_q <= state_d;
    end
  end

  assign q    = state_q;
  assign qbar = ~state_q;

endmodule

// File: rtl/jk_counter_bank.sv
// Bank of JK cells steered into raw-JK, up/down counter or parallel-load
// behaviour, with a terminal-count flag and a registered boundary pulse.
module jk_counter_bank
  import jk_counter_bank_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             ovf
);

  logic [WIDTH-1:0] q_w;
  logic [WIDTH-1:0] qbar_w;
  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] dn_t;
  logic [WIDTH-1:0] j_cell;
  logic [WIDTH-1:0] k_cell;
  logic             tc_c;
  logic             ovf_q;
  logic             ovf_d;

  // Ripple-carry toggle terms: bit i toggles when all lower bits are 1 (up) or 0 (down).
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cells
      if (gi == 0) begin : g_lsb
        assign up_t[gi] = 1'b1;
        assign dn_t[gi] = 1'b1;
      end else begin : g_upper
        assign up_t[gi] = up_t[gi-1] & q_w[gi-1];
        assign dn_t[gi] = dn_t[gi-1] & qbar_w[gi-1];
      end

      jk_cell u_cell (
        .clk  (clk),
        .rst  (rst),
        .j    (j_cell[gi]),
        .k    (k_cell[gi]),
        .q    (q_w[gi]),
        .qbar (qbar_w[gi])
      );
    end
  endgenerate

  always_comb begin
    tc_c = 1'b0;
    if (en) begin
      case (mode)
        MODE_UP:   tc_c = &q_w;
        MODE_DOWN: tc_c = ~|q_w;
        default:   tc_c = 1'b0;
      endcase
    end
  end

  // A saturating boundary step holds every cell by forcing J=K=0.
  always_comb begin
    j_cell = '0;
    k_cell = '0;
    if (en && !(SATURATE && tc_c)) begin
      case (mode)
        MODE_JK: begin
          j_cell = j;
          k_cell = k;
        end
        MODE_UP: begin
          j_cell = up_t;
          k_cell = up_t;
        end
        MODE_DOWN: begin
          j_cell = dn_t;
          k_cell = dn_t;
        end
        default: begin
          j_cell = d;
          k_cell = ~d;
        end
      endcase
    end
  end

  assign ovf_d = tc_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign q    = q_w;
  assign qbar = qbar_w;
  assign tc   = tc_c;
  assign ovf  = ovf_q;

endmodule
